// File: rtl/alt_vipswi130_stream_input_buffer_pkg.sv
// Shared definitions for the video switch input buffer: packet type codes and packet state encoding.
// Latency: none (constants, types and a helper function only).
// Backpressure: not applicable.
package alt_vipswi130_stream_input_buffer_pkg;

  // Packet type codes carried in data[3:0] of the SOP beat.
  localparam logic [3:0] PKT_IMAGE = 4'h0;
  localparam logic [3:0] PKT_CTRL  = 4'hF;

  // Input packet tracking state.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } pkt_state_e;

  function automatic logic is_image(input logic [3:0] ptype);
    return ptype == PKT_IMAGE;
  endfunction

endpackage

// File: rtl/alt_vipswi130_stream_input_buffer_if.sv
// Avalon-ST style video stream bundle: valid/ready handshake plus data, sop and eop.
// Latency: none (wiring only).
// Backpressure: ready-latency 0; a beat moves when valid & ready.
// Ports: master drives valid/data/sop/eop and reads ready; slave is the mirror image.
interface alt_vipswi130_stream_input_buffer_if #(
  parameter int DATA_WIDTH = 10
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic                  sop;
  logic                  eop;

  modport master (output valid, data, sop, eop, input ready);
  modport slave  (input valid, data, sop, eop, output ready);
endinterface

// File: rtl/alt_vipswi130_skid_fifo2.sv
// Two-entry FIFO of {data, sop, eop} with a registered input ready.
// Latency: a beat written into an empty buffer is visible at the output on the next cycle.
// Backpressure: in_rdy <= (count_next != 2), so a write can never find the buffer full.
// Ports: clk/rst_n; push + push_* write side with in_rdy; out_vld/out_* head with out_rdy pop.
module alt_vipswi130_skid_fifo2 #(
  parameter int DATA_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  push_sop,
  input  logic                  push_eop,
  output logic                  in_rdy,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sop,
  output logic                  out_eop
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  sop;
    logic                  eop;
  } entry_t;

  entry_t     head_q, tail_q, new_ent;
  logic [1:0] count_q, count_next;
  logic       in_rdy_q;
  logic       wr, rd;

  assign new_ent = '{data: push_data, sop: push_sop, eop: push_eop};
  assign wr      = push & in_rdy_q;
  assign rd      = out_rdy & (count_q != 2'd0);

  always_comb begin
    count_next = count_q;
    case ({wr, rd})
      2'b10:   count_next = count_q + 2'd1;
      2'b01:   count_next = count_q - 2'd1;
      default: count_next = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= 2'd0;
      in_rdy_q <= 1'b0;
      head_q   <= '0;
      tail_q   <= '0;
    end else begin
      count_q  <= count_next;
      in_rdy_q <= (count_next != 2'd2);
      if (rd) begin
        // With two entries the tail moves up (no write is possible then);
        // with one entry a simultaneous write lands directly in the head.
        if (count_q == 2'd2)
          head_q <= tail_q;
        else if (wr)
          head_q <= new_ent;
      end else if (wr) begin
        if (count_q == 2'd0)
          head_q <= new_ent;
        else
          tail_q <= new_ent;
      end
    end
  end

  assign in_rdy   = in_rdy_q;
  assign out_vld  = (count_q != 2'd0);
  assign out_data = head_q.data;
  assign out_sop  = head_q.sop;
  assign out_eop  = head_q.eop;

endmodule

// File: rtl/alt_vipswi130_stream_input_buffer.sv
// Video switch input stage: packet type decode, optional whole-packet discard, 2-entry skid buffer.
// Latency: din to int_valid is 1 cycle into an empty buffer; 1 beat/cycle with int_ready high.
// Backpressure: din.ready is registered and drops once both buffer entries are occupied.
// Ports: clk, rst_n; din (slave stream in); int_bus (master stream out); drop request;
//        pkt_type, image_done, frame_err and dropping status to the switch controller.
module alt_vipswi130_stream_input_buffer
  import alt_vipswi130_stream_input_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  alt_vipswi130_stream_input_buffer_if.slave  din,
  alt_vipswi130_stream_input_buffer_if.master int_bus,
  input  logic       drop,
  output logic [3:0] pkt_type,
  output logic       image_done,
  output logic       frame_err,
  output logic       dropping
);

  pkt_state_e            state_q;
  logic [3:0]            pkt_type_q, type_now;
  logic                  image_done_q, frame_err_q;
  logic                  din_rdy, accept, in_pkt, fwd;
  logic                  out_vld, out_sop, out_eop;
  logic [DATA_WIDTH-1:0] out_data;

  assign accept   = din.valid & din_rdy;
  assign in_pkt   = (state_q != IDLE);
  // Type of the packet this beat belongs to; a SOP beat carries its own.
  assign type_now = din.sop ? din.data[3:0] : pkt_type_q;
  // Only beats of a passing packet reach the buffer; dropped and
  // out-of-packet beats are accepted and thrown away.
  assign fwd      = accept & (din.sop ? ~drop : (state_q == PASS));

  alt_vipswi130_skid_fifo2 #(.DATA_WIDTH(DATA_WIDTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fwd),
    .push_data (din.data),
    .push_sop  (din.sop),
    .push_eop  (din.eop),
    .in_rdy    (din_rdy),
    .out_vld   (out_vld),
    .out_rdy   (int_bus.ready),
    .out_data  (out_data),
    .out_sop   (out_sop),
    .out_eop   (out_eop)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pkt_type_q   <= PKT_CTRL;
      image_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      image_done_q <= accept & din.eop & (din.sop | in_pkt) & is_image(type_now);
      frame_err_q  <= accept & din.sop & in_pkt;
      if (accept) begin
        if (din.sop) begin
          pkt_type_q <= din.data[3:0];
          if (din.eop)
            state_q <= IDLE;
          else if (drop)
            state_q <= DROP;
          else
            state_q <= PASS;
        end else if (din.eop) begin
          state_q <= IDLE;
        end
      end
    end
  end

  assign din.ready     = din_rdy;
  assign int_bus.valid = out_vld;
  assign int_bus.data  = out_data;
  assign int_bus.sop   = out_sop;
  assign int_bus.eop   = out_eop;
  assign pkt_type      = pkt_type_q;
  assign image_done    = image_done_q;
  assign frame_err     = frame_err_q;
  assign dropping      = (state_q == DROP);

endmodule

// File: doc/alt_vipswi130_stream_input_buffer.md
Name: alt_vipswi130_stream_input_buffer

Overview:
Input stage of the video switch. It accepts one Avalon-ST video input, buffers it in a 2-entry skid buffer, and presents it on the internal int_* interface consumed by the switch's stream output stage. It decodes the packet type at SOP, can discard whole packets on request, and reports image-frame boundaries and framing errors to the switch controller.

Parameters:
DATA_WIDTH, 10, width of din_data / int_data; the packet type is carried in bits [3:0] on the SOP beat.

Ports:
clk  in  1  single clock
rst_n  in  1  reset; asynchronous, active-low
din_ready  out  1  registered ready to upstream
din_valid  in  1  upstream beat valid
din_data  in  DATA_WIDTH  upstream data
din_sop  in  1  start of packet
din_eop  in  1  end of packet
int_ready  in  1  downstream (stream output stage) ready
int_valid  out  1  buffer head valid
int_data  out  DATA_WIDTH  buffer head data
int_sop  out  1  buffer head SOP
int_eop  out  1  buffer head EOP
drop  in  1  request to discard packets; sampled at SOP only
pkt_type  out  4  type of the packet currently entering; held between SOPs
image_done  out  1  one-cycle pulse: EOP of an image packet (type 0) accepted from din
frame_err  out  1  one-cycle pulse: SOP accepted while inside a packet
dropping  out  1  current input packet is being discarded

Behaviour:
- Handshake is ready-latency 0. An input transfer happens when din_valid & din_ready. An output transfer happens when int_valid & int_ready.
- Storage: 2 entries of {data, sop, eop}, FIFO order, occupancy count 0..2.
- int_valid = (count != 0). int_* always shows the oldest entry. The head does not change while int_valid & ~int_ready.
- din_ready is a flop: din_ready <= (count_next != 2). Overflow is therefore impossible.
- When count==1, the buffer may read and write in the same cycle; count is unchanged and order is preserved.
- State machine, state_q:
  - IDLE: no packet in progress.
  - PASS: forwarding a packet.
  - DROP: discarding a packet.
- Transitions, evaluated on input transfers only:
  - Any state, SOP beat: go to DROP if drop=1, else PASS. pkt_type <= din_data[3:0].
  - If the SOP beat also has EOP set, the state returns to IDLE the same cycle after the beat is handled (single-beat packet).
  - PASS/DROP, EOP beat: go to IDLE.
  - IDLE, non-SOP beat: accepted and discarded; the state stays IDLE. This resyncs after a truncated stream.
- Beats classified as DROP or IDLE-garbage are accepted (din_ready honoured) but never written to the buffer.
- SOP beat while in PASS or DROP:
  - frame_err pulses for 1 cycle.
  - The new packet starts normally.
  - The old packet's tail is not repaired; the downstream stage sees a second SOP.
- image_done pulses 1 cycle after the accepted EOP beat when that packet's pkt_type==0. This applies in PASS and DROP alike, so the controller counts input frames even while discarding.
- dropping = (state_q == DROP).
- Latency: din to int_valid is 1 cycle when the buffer is empty. Throughput is 1 beat/cycle with int_ready held high.
- Reset (rst_n low, async):
  - count=0, int_valid=0, din_ready=0.
  - int_data=0, int_sop=0, int_eop=0.
  - state_q=IDLE, pkt_type=4'hF.
  - image_done=0, frame_err=0.
  - din_ready rises on the first clock after reset release.
- Reset mid-packet flushes the buffer. The next beats are treated as IDLE-garbage until a SOP arrives.
- A change of drop mid-packet has no effect until the next SOP.

Decomposition:
- Shared package/include: packet type constants (PKT_IMAGE=4'h0, PKT_CTRL=4'hF) and the state encodings IDLE/PASS/DROP.
- One sub-module is natural: alt_vipswi130_skid_fifo2. It is the parameterised 2-entry buffer with registered ready and holds count, entry regs and din_ready.
- The top holds the packet state machine, decode and pulses.

Test Plan:
- Image packet pass, int_ready=1: SOP beat data 0, pixels 1..5, EOP on 5 → int_* shows the same 6 beats, 1-cycle latency; image_done pulses once after the EOP; no gaps.
- Backpressure: int_ready=0 for 4 cycles mid-packet, din_valid=1 continuous → buffer reaches 2, din_ready low next cycle; no beat is lost or duplicated; order is preserved after int_ready returns.
- Drop: drop=1 at SOP of a type-0 packet, deasserted mid-packet → the whole packet is consumed with int_valid=0 throughout; dropping=1 for its duration; image_done still pulses; the next packet with drop=0 passes.
- Framing error: SOP, 3 beats, then a new SOP with no EOP → frame_err pulses once; the second packet is forwarded with its SOP; pkt_type updates to the new type.
- Garbage resync: non-SOP beats after reset → accepted, int_valid stays 0; first SOP (type 0xF, control) is forwarded and pkt_type=0xF.
- Async reset mid-packet with 2 entries buffered → int_valid, din_ready and count drop to 0 immediately, without a clock edge; din_ready=1 one cycle after release.
